// File: rtl/egress_port_sink.sv
// Per-port packet consumer for the switch read interface: requests one packet at a time,
// captures its header, checks length/pattern/destination and keeps saturating statistics.
module egress_port_sink #(
    parameter int unsigned PORT_ID = 0,
    parameter int unsigned TIMEOUT = 4096,
    parameter int unsigned CNT_W   = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             pat_chk,
    output logic             ready,
    input  logic             rd_sop,
    input  logic             rd_vld,
    input  logic             rd_eop,
    input  logic [15:0]      rd_data,
    output logic [CNT_W-1:0] pkt_cnt,
    output logic [CNT_W-1:0] word_cnt,
    output logic [CNT_W-1:0] err_len,
    output logic [CNT_W-1:0] err_pat,
    output logic [CNT_W-1:0] err_dest,
    output logic [CNT_W-1:0] err_proto,
    output logic [CNT_W-1:0] err_timeout,
    output logic [15:0]      last_lat,
    output logic [8:0]       last_len,
    output logic [2:0]       last_prio,
    output logic             busy
);

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_REQ      = 3'd1;
    localparam logic [2:0] S_WAIT_SOP = 3'd2;
    localparam logic [2:0] S_WAIT_HDR = 3'd3;
    localparam logic [2:0] S_DATA     = 3'd4;

    logic [2:0]       r_state, w_state_d;
    logic             r_ready;
    logic [15:0]      r_lat, w_lat_d, w_lat_inc;
    logic [8:0]       r_idx, w_idx_d, w_idx_inc, w_idx_new;
    logic [15:0]      r_last_lat, w_last_lat_d;
    logic [8:0]       r_last_len, w_last_len_d;
    logic [2:0]       r_last_prio, w_last_prio_d;
    logic [CNT_W-1:0] r_pkt_cnt, r_word_cnt, r_err_len, r_err_pat;
    logic [CNT_W-1:0] r_err_dest, r_err_proto, r_err_timeout;
    logic             w_inc_pkt, w_inc_word, w_inc_len, w_inc_pat;
    logic             w_inc_dest, w_inc_proto, w_inc_to;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic inc);
        return (inc && (v != {CNT_W{1'b1}})) ? v + 1'b1 : v;
    endfunction

    always_comb begin
        w_state_d     = r_state;
        w_lat_d       = r_lat;
        w_idx_d       = r_idx;
        w_last_lat_d  = r_last_lat;
        w_last_len_d  = r_last_len;
        w_last_prio_d = r_last_prio;
        w_inc_pkt     = 1'b0;
        w_inc_word    = 1'b0;
        w_inc_len     = 1'b0;
        w_inc_pat     = 1'b0;
        w_inc_dest    = 1'b0;
        w_inc_proto   = 1'b0;
        w_inc_to      = 1'b0;
        w_lat_inc     = (r_lat == 16'hFFFF) ? r_lat : r_lat + 16'd1;
        w_idx_inc     = (r_idx == 9'h1FF) ? r_idx : r_idx + 9'd1;
        // Payload count including a word arriving alongside eop.
        w_idx_new     = rd_vld ? w_idx_inc : r_idx;

        case (r_state)
            S_IDLE: begin
                if (en) w_state_d = S_REQ;
            end
            S_REQ: begin
                w_lat_d   = '0;
                w_state_d = S_WAIT_SOP;
            end
            S_WAIT_SOP: begin
                w_lat_d = w_lat_inc;
                if (rd_sop) begin
                    w_last_lat_d = w_lat_inc;
                    w_state_d    = S_WAIT_HDR;
                end else begin
                    if (rd_vld || rd_eop) w_inc_proto = 1'b1;
                    if ({16'd0, w_lat_inc} >= TIMEOUT) begin
                        w_inc_to  = 1'b1;
                        w_state_d = S_IDLE;
                    end
                end
            end
            S_WAIT_HDR: begin
                if (rd_sop) begin
                    w_inc_proto = 1'b1;
                    w_lat_d     = '0;
                end else if (rd_vld) begin
                    w_last_len_d  = rd_data[15:7];
                    w_last_prio_d = rd_data[6:4];
                    w_inc_dest    = (rd_data[3:0] != PORT_ID[3:0]);
                    w_idx_d       = '0;
                    if (rd_eop) begin
                        w_inc_pkt = 1'b1;
                        w_inc_len = (rd_data[15:7] != 9'd0);
                        w_state_d = S_IDLE;
                    end else begin
                        w_state_d = S_DATA;
                    end
                end else if (rd_eop) begin
                    w_inc_proto = 1'b1;
                    w_inc_len   = 1'b1;
                    w_inc_pkt   = 1'b1;
                    w_state_d   = S_IDLE;
                end
            end
            S_DATA: begin
                if (rd_sop) begin
                    w_inc_proto = 1'b1;
                    w_lat_d     = '0;
                    w_state_d   = S_WAIT_HDR;
                end else begin
                    if (rd_vld) begin
                        w_inc_word = 1'b1;
                        w_idx_d    = w_idx_inc;
                        w_inc_pat  = pat_chk && (rd_data != {7'b0, r_idx});
                    end
                    if (rd_eop) begin
                        w_inc_pkt = 1'b1;
                        w_inc_len = (w_idx_new != r_last_len);
                        w_state_d = S_IDLE;
                    end
                end
            end
            default: w_state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= S_IDLE;
            r_ready       <= 1'b0;
            r_lat         <= '0;
            r_idx         <= '0;
            r_last_lat    <= '0;
            r_last_len    <= '0;
            r_last_prio   <= '0;
            r_pkt_cnt     <= '0;
            r_word_cnt    <= '0;
            r_err_len     <= '0;
            r_err_pat     <= '0;
            r_err_dest    <= '0;
            r_err_proto   <= '0;
            r_err_timeout <= '0;
        end else begin
            r_state       <= w_state_d;
            r_ready       <= (w_state_d == S_REQ);
            r_lat         <= w_lat_d;
            r_idx         <= w_idx_d;
            r_last_lat    <= w_last_lat_d;
            r_last_len    <= w_last_len_d;
            r_last_prio   <= w_last_prio_d;
            r_pkt_cnt     <= sat_inc(r_pkt_cnt, w_inc_pkt);
            r_word_cnt    <= sat_inc(r_word_cnt, w_inc_word);
            r_err_len     <= sat_inc(r_err_len, w_inc_len);
            r_err_pat     <= sat_inc(r_err_pat, w_inc_pat);
            r_err_dest    <= sat_inc(r_err_dest, w_inc_dest);
            r_err_proto   <= sat_inc(r_err_proto, w_inc_proto);
            r_err_timeout <= sat_inc(r_err_timeout, w_inc_to);
        end
    end

    assign ready       = r_ready;
    assign busy        = (r_state != S_IDLE);
    assign pkt_cnt     = r_pkt_cnt;
    assign word_cnt    = r_word_cnt;
    assign err_len     = r_err_len;
    assign err_pat     = r_err_pat;
    assign err_dest    = r_err_dest;
    assign err_proto   = r_err_proto;
    assign err_timeout = r_err_timeout;
    assign last_lat    = r_last_lat;
    assign last_len    = r_last_len;
    assign last_prio   = r_last_prio;

endmodule

// File: tb/tb_egress_port_sink.sv
// Directed + randomized bench for egress_port_sink; expectations come from a packet-level model.
module tb_egress_port_sink;

    localparam int unsigned PID = 5;
    localparam int unsigned TO  = 16;

    logic        clk = 1'b0;
    logic        rst, en, pat_chk, ready, rd_sop, rd_vld, rd_eop, busy;
    logic [15:0] rd_data;
    logic [31:0] pkt_cnt, word_cnt, err_len, err_pat, err_dest, err_proto, err_timeout;
    logic [15:0] last_lat;
    logic [8:0]  last_len;
    logic [2:0]  last_prio;

    int checks   = 0;
    int failures = 0;
    int unsigned e_pkt, e_word, e_len, e_pat, e_dest, e_proto, e_to, e_lat, e_llen, e_lprio;

    egress_port_sink #(.PORT_ID(PID), .TIMEOUT(TO), .CNT_W(32)) dut (
        .clk(clk), .rst(rst), .en(en), .pat_chk(pat_chk), .ready(ready),
        .rd_sop(rd_sop), .rd_vld(rd_vld), .rd_eop(rd_eop), .rd_data(rd_data),
        .pkt_cnt(pkt_cnt), .word_cnt(word_cnt), .err_len(err_len), .err_pat(err_pat),
        .err_dest(err_dest), .err_proto(err_proto), .err_timeout(err_timeout),
        .last_lat(last_lat), .last_len(last_len), .last_prio(last_prio), .busy(busy)
    );

    always #5 clk = ~clk;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, ".pkt_cnt"}, pkt_cnt, e_pkt);
        check({tag, ".word_cnt"}, word_cnt, e_word);
        check({tag, ".err_len"}, err_len, e_len);
        check({tag, ".err_pat"}, err_pat, e_pat);
        check({tag, ".err_dest"}, err_dest, e_dest);
        check({tag, ".err_proto"}, err_proto, e_proto);
        check({tag, ".err_timeout"}, err_timeout, e_to);
        check({tag, ".last_lat"}, {16'd0, last_lat}, e_lat);
        check({tag, ".last_len"}, {23'd0, last_len}, e_llen);
        check({tag, ".last_prio"}, {29'd0, last_prio}, e_lprio);
    endtask

    task automatic clear_model;
        {e_pkt, e_word, e_len, e_pat, e_dest, e_proto, e_to} = '0;
        {e_lat, e_llen, e_lprio} = '0;
    endtask

    task automatic wait_ready(output int n);
        n = 0;
        while (ready !== 1'b1 && n < 64) begin
            step;
            n++;
        end
        check("ready_seen", {31'd0, ready}, 1);
    endtask

    // Header then payload words; the last word carries eop. Updates the model except latency.
    task automatic drive_body(input logic [8:0] hlen, input logic [2:0] prio, input logic [3:0] dest,
                              input int nwords, input int bad_idx, input bit gaps);
        logic [15:0] v;
        rd_vld  = 1'b1;
        rd_data = {hlen, prio, dest};
        step;
        for (int i = 0; i < nwords; i++) begin
            if (gaps && $urandom_range(3) == 0) begin
                rd_vld = 1'b0;
                step;
            end
            v       = (i == bad_idx) ? 16'h00FF : 16'(i);
            rd_vld  = 1'b1;
            rd_data = v;
            rd_eop  = (i == nwords - 1);
            if (pat_chk && v != 16'(i)) e_pat++;
            step;
        end
        if (nwords == 0) begin
            rd_vld = 1'b0;
            rd_eop = 1'b1;
            step;
        end
        {rd_vld, rd_eop} = 2'b00;
        rd_data = '0;
        e_pkt++;
        e_word += nwords;
        if (nwords != int'(hlen)) e_len++;
        if (dest != PID[3:0]) e_dest++;
        e_llen  = hlen;
        e_lprio = prio;
    endtask

    task automatic drive_pkt(input int delay, input logic [8:0] hlen, input logic [2:0] prio,
                             input logic [3:0] dest, input int nwords, input int bad_idx,
                             input bit gaps, output int waited);
        wait_ready(waited);
        for (int d = 0; d < delay; d++) begin
            step;
            if (d == 0) check("ready_one_cycle", {31'd0, ready}, 0);
        end
        rd_sop = 1'b1;
        step;
        rd_sop = 1'b0;
        en     = 1'b0;
        e_lat  = delay;
        drive_body(hlen, prio, dest, nwords, bad_idx, gaps);
    endtask

    initial begin
        int n;
        int unsigned len;
        {rst, en, pat_chk, rd_sop, rd_vld, rd_eop} = 6'b100000;
        rd_data = '0;
        clear_model();
        step;
        step;
        check_all("reset");
        check("reset.ready", {31'd0, ready}, 0);
        check("reset.busy", {31'd0, busy}, 0);
        rst = 1'b0;

        // Basic packet, 3-cycle latency.
        en = 1'b1;
        pat_chk = 1'b1;
        drive_pkt(3, 9'd5, 3'd3, PID[3:0], 5, -1, 1'b0, n);
        check_all("t1");
        repeat (4) step;
        check("t1.no_req_en0", {31'd0, ready}, 0);
        check("t1.idle", {31'd0, busy}, 0);

        // Short payload.
        en = 1'b1;
        drive_pkt($urandom_range(1, 10), 9'd31, 3'($urandom), PID[3:0], 30, -1, 1'b1, n);
        check_all("t2");

        // Corrupted word with pattern check on.
        en = 1'b1;
        drive_pkt($urandom_range(1, 10), 9'd8, 3'($urandom), PID[3:0], 8, 2, 1'b0, n);
        check_all("t3");

        // Wrong destination, corrupted word ignored with pattern check off.
        pat_chk = 1'b0;
        en = 1'b1;
        drive_pkt($urandom_range(1, 10), 9'd6, 3'($urandom), 4'(PID + 3), 6, 1, 1'b0, n);
        check_all("t3b");
        pat_chk = 1'b1;

        // Timeout, with a stray vld while waiting for sop.
        en = 1'b1;
        wait_ready(n);
        for (int k = 1; k <= 16; k++) begin
            step;
            rd_vld = (k == 4);
        end
        e_proto++;
        check("t4.before_to", err_timeout, e_to);
        check("t4.busy_wait", {31'd0, busy}, 1);
        step;
        e_to++;
        check("t4.err_timeout", err_timeout, e_to);
        check("t4.idle_ready", {31'd0, ready}, 0);
        check("t4.idle_busy", {31'd0, busy}, 0);
        step;
        check("t4.req_again", {31'd0, ready}, 1);
        drive_pkt(2, 9'd4, 3'd1, PID[3:0], 4, -1, 1'b0, n);
        check_all("t4");

        // sop during DATA abandons the packet; a full packet follows.
        en = 1'b1;
        wait_ready(n);
        repeat (2) step;
        rd_sop = 1'b1;
        step;
        {rd_sop, en} = 2'b00;
        rd_vld  = 1'b1;
        rd_data = {9'd4, 3'd2, PID[3:0]};
        step;
        for (int i = 0; i < 3; i++) begin
            rd_data = 16'(i);
            step;
        end
        rd_vld = 1'b0;
        rd_sop = 1'b1;
        step;
        rd_sop = 1'b0;
        e_proto++;
        e_word += 3;
        e_lat = 2;
        drive_body(9'd7, 3'd6, PID[3:0], 7, -1, 1'b1);
        check_all("t5");

        // Asynchronous reset mid-DATA.
        en = 1'b1;
        wait_ready(n);
        step;
        rd_sop = 1'b1;
        step;
        {rd_sop, en} = 2'b00;
        rd_vld  = 1'b1;
        rd_data = {9'd9, 3'd4, PID[3:0]};
        step;
        for (int i = 0; i < 4; i++) begin
            rd_data = 16'(i);
            step;
        end
        #2;
        rst = 1'b1;
        #1;
        clear_model();
        check_all("t6");
        check("t6.ready", {31'd0, ready}, 0);
        check("t6.busy", {31'd0, busy}, 0);
        step;
        {rst, rd_vld} = 2'b00;
        rd_data = '0;
        step;
        check("t6.stay_idle", {31'd0, busy}, 0);

        // Back-to-back random packets.
        for (int k = 0; k < 30; k++) begin
            en  = 1'b1;
            len = $urandom_range(31, 511);
            drive_pkt($urandom_range(1, 10), 9'(len), 3'($urandom), PID[3:0], int'(len), -1,
                      1'b1, n);
            check("t7.req_gap", n, 1);
        end
        check_all("t7");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
